// File: rtl/uart_rx_fifo.sv
// Buffers bytes from the UART receiver in a circular FIFO with a show-ahead read port.
// Latency: a byte whose rx_ready is sampled in S_WAIT is on rd_data one cycle later, alongside the rx_reset_ready pulse.
// Backpressure: none toward the receiver; every byte is acknowledged, and a byte that meets a full FIFO is dropped and sets the sticky overflow flag.
module uart_rx_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      rx_data,
  input  logic                  rx_ready,
  output logic                  rx_reset_ready,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  input  logic                  clr_overflow
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = DEPTH[DEPTH_LOG2:0];

  typedef enum logic [1:0] {
    S_WAIT,
    S_ACK,
    S_HOLD
  } cap_state_t;

  cap_state_t state, state_nxt;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  wr_try;
  logic                  wr_do;
  logic                  pop;
  logic                  drop;

  // Status comes only from registered count, so no input reaches these outputs combinationally.
  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign rd_data = mem[rd_ptr];

  // A pop needs a stored entry; a byte landing in an empty FIFO cannot be popped the same cycle.
  assign pop    = rd_en && !empty;
  assign wr_try = (state == S_WAIT) && rx_ready;
  assign wr_do  = wr_try && (!full || pop);
  assign drop   = wr_try && full && !pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_WAIT;
    end else begin
      state <= state_nxt;
    end
  end

  // S_HOLD waits out the receiver's ready level so a late-dropping ready cannot cause a second write.
  always_comb begin
    state_nxt      = state;
    rx_reset_ready = 1'b0;
    case (state)
      S_WAIT: begin
        if (rx_ready) begin
          state_nxt = S_ACK;
        end
      end
      S_ACK: begin
        rx_reset_ready = 1'b1;
        state_nxt      = S_HOLD;
      end
      S_HOLD: begin
        if (!rx_ready) begin
          state_nxt = S_WAIT;
        end
      end
      default: begin
        state_nxt = S_WAIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_do) begin
      mem[wr_ptr] <= rx_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_do) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      case ({wr_do, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed, table-driven bench for uart_rx_fifo with hand-written multi-cycle sequences.
module tb_uart_rx_fifo;

  logic       clk;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rx_reset_ready;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overflow;
  logic       clr_overflow;

  int checks;
  int failures;

  uart_rx_fifo #(.WIDTH(8), .DEPTH_LOG2(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .rx_data        (rx_data),
    .rx_ready       (rx_ready),
    .rx_reset_ready (rx_reset_ready),
    .rd_en          (rd_en),
    .rd_data        (rd_data),
    .empty          (empty),
    .full           (full),
    .count          (count),
    .overflow       (overflow),
    .clr_overflow   (clr_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ready;
    logic [7:0] data;
    logic       rd;
    logic       clr;
    logic       exp_ack;
    logic [4:0] exp_count;
    logic       exp_empty;
    logic       exp_full;
    logic       exp_ovf;
    logic       chk_data;
    logic [7:0] exp_data;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] model[$];

  function automatic void add(input logic ready, input logic [7:0] data, input logic rd,
                              input logic ack, input logic [4:0] cnt, input logic chk,
                              input logic [7:0] exp_data);
    vec_t v;
    v.ready     = ready;
    v.data      = data;
    v.rd        = rd;
    v.clr       = 1'b0;
    v.exp_ack   = ack;
    v.exp_count = cnt;
    v.exp_empty = (cnt == 5'd0);
    v.exp_full  = (cnt == 5'd16);
    v.exp_ovf   = 1'b0;
    v.chk_data  = chk;
    v.exp_data  = exp_data;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One byte through the full handshake: sample in S_WAIT, ack cycle, hold cycle back to S_WAIT.
  task automatic send_byte(input logic [7:0] d, input logic with_pop, input logic with_clr);
    rx_ready     = 1'b1;
    rx_data      = d;
    rd_en        = with_pop;
    clr_overflow = with_clr;
    tick();
    rx_ready     = 1'b0;
    rd_en        = 1'b0;
    clr_overflow = 1'b0;
    check($sformatf("ack byte %0h", d), {31'd0, rx_reset_ready}, 32'd1);
    tick();
    tick();
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
    check(name, {24'd0, rd_data}, {24'd0, exp});
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    reset        = 1'b1;
    rx_data      = 8'h00;
    rx_ready     = 1'b0;
    rd_en        = 1'b0;
    clr_overflow = 1'b0;

    // Single byte with ready held for 10 cycles, then empty-FIFO write+read and underflow.
    add(1'b1, 8'hA5, 1'b0, 1'b1, 5'd1, 1'b1, 8'hA5);
    for (int k = 0; k < 9; k++) add(1'b1, 8'hA5, 1'b0, 1'b0, 5'd1, 1'b1, 8'hA5);
    add(1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b1, 8'hA5);
    add(1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 8'h00);
    add(1'b1, 8'h3C, 1'b1, 1'b1, 5'd1, 1'b1, 8'h3C);
    add(1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b1, 8'h3C);
    add(1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b1, 8'h3C);
    add(1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 8'h00);
    add(1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 8'h00);

    tick();
    tick();
    check("reset empty", {31'd0, empty}, 32'd1);
    check("reset full", {31'd0, full}, 32'd0);
    check("reset count", {27'd0, count}, 32'd0);
    check("reset overflow", {31'd0, overflow}, 32'd0);
    check("reset ack", {31'd0, rx_reset_ready}, 32'd0);
    reset = 1'b0;
    tick();
    check("idle count", {27'd0, count}, 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      rx_ready     = vecs[i].ready;
      rx_data      = vecs[i].data;
      rd_en        = vecs[i].rd;
      clr_overflow = vecs[i].clr;
      tick();
      check($sformatf("vec%0d ack", i), {31'd0, rx_reset_ready}, {31'd0, vecs[i].exp_ack});
      check($sformatf("vec%0d count", i), {27'd0, count}, {27'd0, vecs[i].exp_count});
      check($sformatf("vec%0d empty", i), {31'd0, empty}, {31'd0, vecs[i].exp_empty});
      check($sformatf("vec%0d full", i), {31'd0, full}, {31'd0, vecs[i].exp_full});
      check($sformatf("vec%0d overflow", i), {31'd0, overflow}, {31'd0, vecs[i].exp_ovf});
      if (vecs[i].chk_data) begin
        check($sformatf("vec%0d rd_data", i), {24'd0, rd_data}, {24'd0, vecs[i].exp_data});
      end
    end
    rx_ready = 1'b0;
    rd_en    = 1'b0;

    // Fill to full, then drop a 17th byte.
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0, 1'b0);
    check("fill full", {31'd0, full}, 32'd1);
    check("fill count", {27'd0, count}, 32'd16);
    check("fill overflow", {31'd0, overflow}, 32'd0);
    send_byte(8'hFF, 1'b0, 1'b0);
    check("drop overflow", {31'd0, overflow}, 32'd1);
    check("drop count", {27'd0, count}, 32'd16);
    check("drop head", {24'd0, rd_data}, 32'h00);

    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("clr overflow", {31'd0, overflow}, 32'd0);

    // Full with a same-cycle pop stores the byte; full without pop plus clear keeps overflow set.
    send_byte(8'hEE, 1'b1, 1'b0);
    check("full+pop count", {27'd0, count}, 32'd16);
    check("full+pop overflow", {31'd0, overflow}, 32'd0);
    check("full+pop head", {24'd0, rd_data}, 32'h01);
    send_byte(8'hDD, 1'b0, 1'b1);
    check("set wins overflow", {31'd0, overflow}, 32'd1);
    check("set wins count", {27'd0, count}, 32'd16);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("clr overflow 2", {31'd0, overflow}, 32'd0);

    for (int i = 1; i < 16; i++) pop_check($sformatf("drain %0d", i), 8'(i));
    check("drain full", {31'd0, full}, 32'd0);
    pop_check("drain last", 8'hEE);
    check("drain empty", {31'd0, empty}, 32'd1);
    check("drain count", {27'd0, count}, 32'd0);

    // Three rounds of 10 writes / 10 reads crossing the pointer wrap.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 10; i++) begin
        send_byte(8'(8'h10 + r * 10 + i), 1'b0, 1'b0);
        model.push_back(8'(8'h10 + r * 10 + i));
      end
      check($sformatf("wrap%0d count", r), {27'd0, count}, 32'd10);
      for (int i = 0; i < 10; i++) pop_check($sformatf("wrap%0d pop%0d", r, i), model.pop_front());
    end
    check("wrap end count", {27'd0, count}, 32'd0);
    check("wrap end empty", {31'd0, empty}, 32'd1);

    // Reset arriving mid-ack drops the pulse at once and returns capture to S_WAIT.
    rx_ready = 1'b1;
    rx_data  = 8'h55;
    tick();
    check("pre-reset ack", {31'd0, rx_reset_ready}, 32'd1);
    check("pre-reset count", {27'd0, count}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async reset ack", {31'd0, rx_reset_ready}, 32'd0);
    check("async reset count", {27'd0, count}, 32'd0);
    check("async reset empty", {31'd0, empty}, 32'd1);
    rx_ready = 1'b0;
    #1 reset = 1'b0;
    tick();
    check("post-reset ack", {31'd0, rx_reset_ready}, 32'd0);
    rx_ready = 1'b1;
    rx_data  = 8'h77;
    tick();
    rx_ready = 1'b0;
    check("post-reset capture ack", {31'd0, rx_reset_ready}, 32'd1);
    check("post-reset capture count", {27'd0, count}, 32'd1);
    check("post-reset capture data", {24'd0, rd_data}, 32'h77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Downstream consumer of the UART receiver. Takes each received byte via the receiver's level `ready` / `reset_ready` acknowledge handshake and stores it in a circular FIFO. Presents the bytes to the rest of the FPGA design through a show-ahead read port. Decouples byte arrival at line rate from a consumer that may stall, and flags bytes lost to overflow.

Parameters:
- WIDTH, 8, data byte width; matches the receiver data bus.
- DEPTH_LOG2, 4, log2 of FIFO depth (default 16 entries).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- rx_data  in  WIDTH  byte from receiver; valid while rx_ready=1.
- rx_ready  in  1  receiver byte-available level; stays high until acknowledged.
- rx_reset_ready  out  1  one-cycle acknowledge pulse to the receiver's reset_ready input.
- rd_en  in  1  pop head entry; ignored when empty=1.
- rd_data  out  WIDTH  head entry, show-ahead; don't-care when empty.
- empty  out  1  FIFO holds 0 entries.
- full  out  1  FIFO holds 2^DEPTH_LOG2 entries.
- count  out  DEPTH_LOG2+1  current occupancy.
- overflow  out  1  sticky: a byte was dropped because the FIFO was full.
- clr_overflow  in  1  synchronous clear of overflow.

Behaviour:
- Reset (asynchronous, any time, including mid-handshake):
  - wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, overflow=0, rx_reset_ready=0.
  - Capture FSM goes to sWait.
  - FIFO contents are not cleared (don't-care).
- Storage: 2^DEPTH_LOG2 x WIDTH register array.
  - wr_ptr and rd_ptr are DEPTH_LOG2 bits and wrap modulo depth.
  - count is tracked separately; empty = (count==0), full = (count==2^DEPTH_LOG2).
  - All status outputs are registered-state derived, with no combinational path from inputs.
- Capture FSM, 3 states:
  - sWait: rx_ready=1 -> perform write attempt this cycle, next state sAck. Otherwise stay in sWait.
  - sAck: rx_reset_ready=1 for exactly this cycle; next state sHold.
  - sHold: stay until rx_ready=0, then go to sWait. This guarantees one write per received byte even if the receiver drops ready late.
  - rx_reset_ready=0 in all states except sAck.
- Write attempt (sWait with rx_ready=1):
  - If not full, or full with a pop occurring in the same cycle: write rx_data at wr_ptr and increment wr_ptr.
  - If full with no pop that cycle: drop the byte, set overflow=1, leave pointers unchanged. The byte is still acknowledged so the receiver never stalls.
- Read:
  - rd_data = mem[rd_ptr] combinationally from registered state.
  - rd_en=1 with empty=0: rd_ptr increments on the clock edge and the next entry appears the following cycle.
  - rd_en with empty=1: no effect; no underflow flag.
- Simultaneous write and pop:
  - count unchanged; both pointers advance.
  - When empty, a write and an rd_en in the same cycle do not pop: the read is ignored and count goes to 1.
- Count arithmetic: +1 on write only, -1 on pop only, unchanged on both or neither. Never exceeds 2^DEPTH_LOG2 and never goes below 0.
- Latency:
  - rx_ready rising (sampled in sWait) -> byte visible on rd_data / empty=0 one cycle later.
  - rx_reset_ready pulses on that same following cycle.
- Overflow:
  - Set by a dropped byte; cleared by clr_overflow=1.
  - If a drop and clr_overflow occur in the same cycle, set wins.

Test Plan:
- Reset then idle -> empty=1, full=0, count=0, overflow=0, rx_reset_ready=0.
- Single byte, rx_data=8'hA5, rx_ready held high for 10 cycles:
  - Exactly one rx_reset_ready pulse, one cycle after ready is first sampled.
  - count=1, rd_data=8'hA5.
  - Ready remaining high causes no second write.
- Write 16 bytes 8'h00..8'h0F with rd_en=0:
  - full=1, count=16.
  - A 17th byte 8'hFF is acknowledged, overflow=1, count stays 16.
  - Popping 16 times yields 8'h00..8'h0F in order, then empty=1.
- Wrap-around: write 10 / read 10, three times (30 bytes, 8'h10 upward):
  - Data order preserved across the pointer wrap; count=0 at the end.
- With full=1, a byte arrives in the same cycle as rd_en=1 -> byte stored, count stays 16, no overflow. Check also a same-cycle write+rd_en while empty -> count=1, no pop.
- Reset asserted during sAck, and overflow clear:
  - Reset during sAck -> rx_reset_ready drops immediately (asynchronously), count=0, FSM returns to sWait.
  - Overflow set, then clr_overflow pulsed -> overflow=0 next cycle.
